instruction_fetch: RTL
======================

# instruction_fetch

Pipeline IF stage of the MIPS core: owns the program counter, the instruction memory and the IF/ID pipeline register, and feeds `instruction_decode` with the fetched word and its PC+4. It accepts jump/branch redirects and load-use stalls from decode, and debug-unit halt/step control. It also provides a program-load write port into instruction memory. It detects the end-of-program word and stops fetching.

## Interface
- `NB_DATA`, 32, data/instruction/PC width
- `NB_IMEM_ADDR`, 8, instruction-memory word-address width (2^8 = 256 words)
- `clk` in 1: core clock, all state on rising edge
- `i_rst` in 1: reset, asynchronous, active-high
- `i_start` in 1: one-cycle pulse; leaves IDLE/END, restarts fetch from PC 0
- `i_halt` in 1: debug freeze; PC, IF/ID register and state hold
- `i_stall` in 1: load-use stall from hazard logic; PC and IF/ID hold
- `i_jump` in 1: taken jump/branch from decode
- `i_addr2jump` in NB_DATA: byte target address, valid with `i_jump`
- `i_we_imem` in 1: program-load write enable
- `i_imem_addr` in NB_IMEM_ADDR: load word address
- `i_imem_data` in NB_DATA: load word
- `o_instruction` out NB_DATA: IF/ID instruction to decode
- `o_pcounter4` out NB_DATA: IF/ID PC+4 of `o_instruction`
- `o_pc` out NB_DATA: current fetch PC
- `o_valid` out 1: `o_instruction` is a real fetched word (0 for NOP bubbles)
- `o_end` out 1: HALT word (32'hFFFFFFFF) has been fetched; sticky until `i_start`/reset

## Operation
- States: IDLE, RUN, END. Reset -> IDLE.
- IDLE: PC held at 0; IF/ID = NOP (32'h0), `o_valid`=0. `i_start` -> RUN.
- RUN, priority per cycle: `i_halt` > `i_stall` > `i_jump` > sequential.
  - halt: nothing changes.
  - stall: PC, IF/ID, state held; a concurrent `i_jump` is ignored (decode re-presents it next cycle).
  - jump: PC <= `i_addr2jump`; IF/ID <= NOP, `o_valid`=0 (flush of wrong-path word).
  - sequential: IF/ID <= {imem[PC], PC+4}, `o_valid`=1, PC <= PC+4.
  - Fetched word == 32'hFFFFFFFF (sequential case): IF/ID gets the HALT word with `o_valid`=1, `o_end`<=1, PC not incremented, state -> END.
- END: IF/ID <= NOP, `o_valid`=0 from next edge (HALT word presented exactly once unless halted/stalled that cycle, in which case it is held). `i_start` -> RUN, PC <= 0, `o_end` <= 0.
- `i_start` while RUN: ignored.
- Memory read combinational, index PC[NB_IMEM_ADDR+1:2]; PC[1:0] and bits above index ignored (wrap-around). PC+4 wraps modulo 2^NB_DATA.
- Load port: write at rising edge whenever `i_we_imem`=1, any state. Same-cycle fetch of the written address returns old contents.
- Memory contents not cleared by reset.

## Timing
- Reset values: `o_instruction`=0, `o_pcounter4`=0, `o_pc`=0, `o_valid`=0, `o_end`=0, state IDLE.
- Latency: `i_start` at edge k -> at edge k+1 IF/ID = {imem[0], 4}, `o_pc`=4.
- Jump asserted in cycle n -> edge n+1: `o_pc`=target, IF/ID NOP; edge n+2: IF/ID = imem[target].
- Reset asserted mid-RUN: outputs go to reset values immediately (asynchronous), state IDLE.

## Configuration
- `IF_DELAY_SLOT_EN`: when defined, a taken jump does not flush; IF/ID loads the sequential word fetched in the jump cycle (MIPS delay slot), PC <= target. When undefined, flush-to-NOP as above. Stall/halt priority unchanged either way.

## Structure
- Shared package `mips_pkg`: `HALT_INSTR`=32'hFFFFFFFF, `NOP_INSTR`=32'h0, IF state enum (IDLE/RUN/END), `PC_STEP`=4.
- One sub-module: `instruction_memory` (2^NB_IMEM_ADDR x NB_DATA, one write port, one combinational read port).

## Test plan
- Load imem[0..3]=0x20010005,0x20020007,0x00221820,0xFFFFFFFF, pulse `i_start` -> IF/ID sequence pcounter4 4,8,12,16; `o_end`=1 with HALT word; next cycle NOP, `o_valid`=0, `o_pc` stays 12.
- In RUN at PC=8 assert `i_jump` with `i_addr2jump`=0x40 -> next edge IF/ID NOP, `o_pc`=0x40; following edge IF/ID=imem[16], `o_pcounter4`=0x44 (with `IF_DELAY_SLOT_EN`: IF/ID=imem[2] instead of NOP).
- Assert `i_stall` 2 cycles with `i_jump` also high -> PC/IF/ID unchanged, jump not taken; on release, sequential fetch resumes.
- `i_halt` for 5 cycles mid-RUN, then release -> outputs frozen for exactly 5 cycles; sequence continues with no skipped or duplicated PC.
- Assert `i_rst` at PC=0x20 mid-cycle -> all outputs 0 immediately, state IDLE; `i_start` -> fetch restarts at imem[0].
- Set PC near top (jump to 0x3FC, NB_IMEM_ADDR=8) -> next fetch index wraps to imem[0], `o_pcounter4`=0x400.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: special instruction words, fetch step size
// and the IF-stage state encoding.
package mips_pkg;

    localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam int unsigned PC_STEP    = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        END
    } if_state_e;

endpackage

// File: rtl/instruction_memory.sv
// Word-addressed instruction store: one synchronous write port for program
// loading, one combinational read port for fetch. Contents are not reset.
module instruction_memory #(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_ADDR = 8
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [NB_ADDR-1:0] waddr_i,
    input  logic [NB_DATA-1:0] wdata_i,
    input  logic [NB_ADDR-1:0] raddr_i,
    output logic [NB_DATA-1:0] rdata_o
);

    logic [NB_DATA-1:0] mem_q [2**NB_ADDR];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read sees the pre-write contents during a same-cycle write.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instruction_fetch.sv
// MIPS IF stage: PC, instruction memory and IF/ID register with halt/stall/
// jump control and end-of-program detection. Define IF_DELAY_SLOT_EN to keep
// the sequential word in IF/ID on a taken jump instead of flushing it.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter int unsigned NB_DATA      = 32,
    parameter int unsigned NB_IMEM_ADDR = 8
) (
    input  logic                    clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic                    i_halt,
    input  logic                    i_stall,
    input  logic                    i_jump,
    input  logic [NB_DATA-1:0]      i_addr2jump,
    input  logic                    i_we_imem,
    input  logic [NB_IMEM_ADDR-1:0] i_imem_addr,
    input  logic [NB_DATA-1:0]      i_imem_data,
    output logic [NB_DATA-1:0]      o_instruction,
    output logic [NB_DATA-1:0]      o_pcounter4,
    output logic [NB_DATA-1:0]      o_pc,
    output logic                    o_valid,
    output logic                    o_end
);

    if_state_e state_q, state_d;

    logic [NB_DATA-1:0] pc_q, pc_d;
    logic [NB_DATA-1:0] instr_q, instr_d;
    logic [NB_DATA-1:0] pc4_q, pc4_d;
    logic               valid_q, valid_d;
    logic               end_q, end_d;

    logic [NB_DATA-1:0] fetch_word;
    logic [NB_DATA-1:0] pc_plus4;

    instruction_memory #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_IMEM_ADDR)
    ) u_imem (
        .clk     (clk),
        .we_i    (i_we_imem),
        .waddr_i (i_imem_addr),
        .wdata_i (i_imem_data),
        .raddr_i (pc_q[NB_IMEM_ADDR+1:2]),
        .rdata_o (fetch_word)
    );

    assign pc_plus4 = pc_q + NB_DATA'(PC_STEP);

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            end_q   <= end_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        end_d   = end_q;

        case (state_q)
            IDLE: begin
                pc_d    = '0;
                instr_d = NB_DATA'(NOP_INSTR);
                pc4_d   = '0;
                valid_d = 1'b0;
                end_d   = 1'b0;
                if (i_start) begin
                    state_d = RUN;
                end
            end

            RUN: begin
                // Halt and stall both freeze everything; a jump under stall is dropped.
                if (!(i_halt || i_stall)) begin
                    if (i_jump) begin
                        pc_d = i_addr2jump;
`ifdef IF_DELAY_SLOT_EN
                        instr_d = fetch_word;
                        pc4_d   = pc_plus4;
                        valid_d = 1'b1;
`else
                        instr_d = NB_DATA'(NOP_INSTR);
                        pc4_d   = '0;
                        valid_d = 1'b0;
`endif
                    end else if (fetch_word == NB_DATA'(HALT_INSTR)) begin
                        instr_d = fetch_word;
                        pc4_d   = pc_plus4;
                        valid_d = 1'b1;
                        end_d   = 1'b1;
                        state_d = END;
                    end else begin
                        instr_d = fetch_word;
                        pc4_d   = pc_plus4;
                        valid_d = 1'b1;
                        pc_d    = pc_plus4;
                    end
                end
            end

            END: begin
                if (i_start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    end_d   = 1'b0;
                    instr_d = NB_DATA'(NOP_INSTR);
                    pc4_d   = '0;
                    valid_d = 1'b0;
                end else if (!(i_halt || i_stall)) begin
                    instr_d = NB_DATA'(NOP_INSTR);
                    pc4_d   = '0;
                    valid_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        o_instruction = instr_q;
        o_pcounter4   = pc4_q;
        o_pc          = pc_q;
        o_valid       = valid_q;
        o_end         = end_q;
    end

endmodule
